// File: rtl/int_muldiv_unit_pkg.sv
// Shared types for the multi-cycle integer multiply/divide unit.
// MulDivOp codes follow the RV32M funct3 encoding.
package int_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(muldiv_op_e op);
        return op inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
    endfunction

    function automatic logic is_rem_op(muldiv_op_e op);
        return op inside {MULDIV_REM, MULDIV_REMU};
    endfunction

    function automatic logic op1_is_signed(muldiv_op_e op);
        return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    endfunction

    function automatic logic op2_is_signed(muldiv_op_e op);
        return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    endfunction

endpackage

// File: rtl/int_muldiv_unit_iter_core.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide, one bit per step.
// Accumulator holds {hi, lo}: product on multiply, {remainder, quotient} on divide.
module int_muldiv_unit_iter_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic                      is_div,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic [2*DATA_WIDTH-1:0]   acc_step_c
);

    localparam int unsigned W = DATA_WIDTH;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [W:0]     add_sum;
    logic [W:0]     shifted;
    logic [W+1:0]   sub_diff;

    // One iteration step plus load/hold selection
    always_comb begin
        add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : (W+1)'(0));
        shifted  = acc_q[2*W-1:W-1];
        sub_diff = {1'b0, shifted} - {2'b00, b_q};

        if (is_div) begin
            if (!sub_diff[W+1]) begin
                acc_step_c = {sub_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_step_c = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else begin
            acc_step_c = {add_sum, acc_q[W-1:1]};
        end

        acc_d = acc_q;
        b_d   = b_q;
        if (load) begin
            acc_d = {W'(0), op_a};
            b_d   = op_b;
        end else if (step) begin
            acc_d = acc_step_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/int_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: handshakes, FSM, sign handling and fast path
// around the iterative core.
module int_muldiv_unit
    import int_muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0] req_op2,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    muldiv_state_e        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    muldiv_op_e           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [W-1:0]         resp_data_q, resp_data_d;
    logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;

    muldiv_op_e     req_op_e;
    logic           op1_neg, op2_neg, neg_res_c;
    logic [W-1:0]   op1_mag, op2_mag;
    logic           div_zero, div_ovf, fast_c;
    logic [W-1:0]   fast_val;
    logic           core_load, core_step;
    logic [2*W-1:0] acc_step_c, prod_c;
    logic [W-1:0]   quo_c, rem_c, calc_res;

    // Operand magnitudes, result sign and divide special cases, from the request inputs
    always_comb begin
        req_op_e  = muldiv_op_e'(req_op);
        op1_neg   = op1_is_signed(req_op_e) & req_op1[W-1];
        op2_neg   = op2_is_signed(req_op_e) & req_op2[W-1];
        op1_mag   = op1_neg ? -req_op1 : req_op1;
        op2_mag   = op2_neg ? -req_op2 : req_op2;
        neg_res_c = is_rem_op(req_op_e) ? op1_neg : (op1_neg ^ op2_neg);
        div_zero  = (req_op2 == '0);
        div_ovf   = is_div_op(req_op_e) && op2_is_signed(req_op_e)
                    && (req_op1 == MIN_INT) && (req_op2 == '1);
        fast_c    = is_div_op(req_op_e) && (div_zero || div_ovf);
        if (div_zero) begin
            fast_val = is_rem_op(req_op_e) ? req_op1 : '1;
        end else begin
            fast_val = is_rem_op(req_op_e) ? '0 : MIN_INT;
        end
    end

    // Sign fix-up and half selection on the final step's accumulator value
    always_comb begin
        prod_c = neg_q ? -acc_step_c : acc_step_c;
        quo_c  = neg_q ? -acc_step_c[W-1:0] : acc_step_c[W-1:0];
        rem_c  = neg_q ? -acc_step_c[2*W-1:W] : acc_step_c[2*W-1:W];
        case (op_q)
            MULDIV_MUL:                              calc_res = prod_c[W-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: calc_res = prod_c[2*W-1:W];
            MULDIV_DIV, MULDIV_DIVU:                 calc_res = quo_c;
            default:                                 calc_res = rem_c;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        neg_d        = neg_q;
        tag_d        = tag_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        core_load    = 1'b0;
        core_step    = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (req_valid && req_ready_q && !flush) begin
                    op_d        = req_op_e;
                    neg_d       = neg_res_c;
                    tag_d       = req_tag;
                    req_ready_d = 1'b0;
                    if (fast_c) begin
                        state_d      = MD_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = fast_val;
                        resp_tag_d   = req_tag;
                    end else begin
                        state_d   = MD_CALC;
                        cnt_d     = '0;
                        core_load = 1'b1;
                    end
                end
            end
            MD_CALC: begin
                core_step = 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d      = MD_DONE;
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = calc_res;
                    resp_tag_d   = tag_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MD_DONE: begin
                if (resp_ready) begin
                    state_d      = MD_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        // Flush overrides everything: abandon the op, no response
        if (flush) begin
            state_d      = MD_IDLE;
            cnt_d        = '0;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
            core_load    = 1'b0;
            core_step    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
            op_q         <= MULDIV_MUL;
            neg_q        <= 1'b0;
            tag_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            tag_q        <= tag_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    int_muldiv_unit_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter_core (
        .clk        (clk),
        .rst        (rst),
        .load       (core_load),
        .step       (core_step),
        .is_div     (is_div_op(op_q)),
        .op_a       (op1_mag),
        .op_b       (op2_mag),
        .acc_step_c (acc_step_c)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_int_muldiv_unit.sv
// Scoreboard bench for int_muldiv_unit: directed RV32M cases, handshake stalls,
// flush/reset aborts and random operands against a 64-bit arithmetic model.
module tb_int_muldiv_unit;
    import int_muldiv_unit_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 5;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic          clk, rst, flush;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_op1, req_op2;
    logic [TW-1:0] req_tag;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rv_prev = 1'b0;

    int_muldiv_unit #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == MIN_INT) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return MIN_INT;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf = (op == 3'd4 || op == 3'd6) && (a == MIN_INT) && (b == 32'hFFFF_FFFF);
        return (op[2] && (b == 0 || ovf)) ? 1 : 33;
    endfunction

    // Response monitor: latency on rise of resp_valid, data/tag on handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resp_valid && !rv_prev && sb_q.size() > 0)
                check_eq("latency", 32'(cyc - sb_q[0].acc_cyc + 1), 32'(sb_q[0].lat));
            if (resp_valid && resp_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("resp_data", resp_data, e.data);
                    check_eq("resp_tag", {27'b0, resp_tag}, {27'b0, e.tag});
                end
            end
        end
        rv_prev = resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input logic [31:0] exp_data, input bit push);
        exp_t e;
        int   n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check_eq("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        req_op1   = $urandom;
        req_op2   = $urandom;
        req_tag   = TW'($urandom);
        if (push) begin
            e.data    = exp_data;
            e.tag     = tag;
            e.lat     = exp_lat(op, a, b);
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("resp_valid_arrives", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (resp_valid) hits++;
        end
        check_eq(name, 32'(hits), 32'd0);
        tick();
    endtask

    task automatic check_reset_values(input string pfx);
        @(negedge clk);
        check_eq({pfx, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check_eq({pfx, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check_eq({pfx, "_resp_data"}, resp_data, 32'd0);
        check_eq({pfx, "_resp_tag"}, {27'b0, resp_tag}, 32'd0);
        tick();
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_op1 = '0; req_op2 = '0; req_tag = '0; resp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_values("reset");

        // Directed arithmetic cases with hand-derived results
        send(MULDIV_MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b1);
        send(MULDIV_MULH,   MIN_INT,       MIN_INT,       5'd4,  32'h4000_0000, 1'b1);
        send(MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1'b1);
        send(MULDIV_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b1);
        send(MULDIV_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 1'b1);
        send(MULDIV_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b1);
        send(MULDIV_DIVU,   32'd100,       32'd7,         5'd10, 32'd14,        1'b1);
        // Requests while busy must be ignored
        req_valid = 1'b1; req_op = MULDIV_MUL; req_op1 = 32'd5; req_op2 = 32'd5;
        repeat (5) tick();
        req_valid = 1'b0;
        send(MULDIV_REMU,   32'd100,       32'd7,         5'd11, 32'd2,         1'b1);
        send(MULDIV_DIV,    32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1'b1);
        send(MULDIV_REM,    32'd5,         32'd0,         5'd13, 32'd5,         1'b1);
        send(MULDIV_DIV,    MIN_INT,       32'hFFFF_FFFF, 5'd14, MIN_INT,       1'b1);
        send(MULDIV_REM,    MIN_INT,       32'hFFFF_FFFF, 5'd15, 32'd0,         1'b1);
        send(MULDIV_REMU,   32'd9,         32'd0,         5'd16, 32'd9,         1'b1);
        drain();

        // Back-pressure: result held stable while resp_ready is low
        resp_ready = 1'b0;
        send(MULDIV_MUL, 32'd6, 32'd7, 5'd9, 32'd42, 1'b1);
        wait_resp_valid();
        repeat (10) begin
            @(negedge clk);
            check_eq("stall_data", resp_data, 32'd42);
            check_eq("stall_tag", {27'b0, resp_tag}, 32'd9);
            check_eq("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("handshake_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("req_ready_return", {31'b0, req_ready}, 32'd1);
        check_eq("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
        tick();

        // Flush in CALC cycle 5
        send(MULDIV_DIV, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_calc_ready", {31'b0, req_ready}, 32'd1);
        expect_quiet("flush_calc_no_resp", 40);

        // Flush in DONE with resp_ready high drops the result
        resp_ready = 1'b0;
        send(MULDIV_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22, 32'd0, 1'b0);
        wait_resp_valid();
        flush = 1'b1;
        resp_ready = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_done_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("flush_done_ready", {31'b0, req_ready}, 32'd1);
        tick();
        send(MULDIV_REMU, 32'd100, 32'd7, 5'd21, 32'd2, 1'b1);
        drain();

        // Request during flush is not accepted
        req_valid = 1'b1; req_op = MULDIV_MUL; req_op1 = 32'd3; req_op2 = 32'd3; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check_eq("flush_blocks_accept", {31'b0, req_ready}, 32'd1);
        expect_quiet("flush_idle_no_resp", 40);

        // Reset mid-CALC
        send(MULDIV_DIVU, 32'd12345, 32'd17, 5'd23, 32'd0, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst_mid");
        expect_quiet("rst_mid_no_resp", 40);
        send(MULDIV_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd24, 32'd1, 1'b1);
        drain();

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = MIN_INT;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            send(op, a, b, TW'(i), model(op, a, b), 1'b1);
        end
        drain();
        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
